// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: stage occupancy states and
// the default filler word shown while a stage holds nothing.
package pipe_pkg;

  // Encoding is chosen so the state value equals the number of held words.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int   DEFAULT_WIDTH = 48;
  localparam logic NOP_FILL_BIT  = 1'b0;

  function automatic logic [1:0] held_count(input stage_state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: one main register plus an optional skid
// register, valid/ready handshakes on both sides, flush squash and NOP fill.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{NOP_FILL_BIT}},
  parameter int               SKID      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             push, pop;

  // Every output is decoded from registered state only, never from inputs.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q == ST_EMPTY) || ((SKID != 0) && (state_q == ST_BUSY));
  assign out_data  = out_valid ? main_q : NOP_VALUE;
  assign occupancy = held_count(state_q);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred; blocking '=' is correct here.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_BUSY;
          main_d  = in_data;
        end
      end
      ST_BUSY: begin
        // With SKID=0 in_ready is low here, so push never occurs in BUSY.
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // from the same pre-edge values.
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // NOTE: the payload registers are deliberately not reset; out_data is masked
  // to NOP_VALUE by out_valid, so their contents while empty never leak out.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table (SKID=1),
// hand sequence (SKID=0), and randomized traffic against a queue model.
module tb_pipe_stage_reg;

  localparam int               W     = 48;
  localparam logic [W-1:0]     A_NOP = '0;
  localparam logic [W-1:0]     B_NOP = 48'h0000_BEEF_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default (SKID=1, NOP all-zeros); instance B: SKID=0.
  logic         rst_a, flush_a, iv_a, ordy_a, ir_a, ov_a;
  logic [W-1:0] id_a, od_a;
  logic [1:0]   occ_a;
  logic         rst_b, flush_b, iv_b, ordy_b, ir_b, ov_b;
  logic [W-1:0] id_b, od_b;
  logic [1:0]   occ_b;

  pipe_stage_reg u_dut_a (
    .clk(clk), .rst(rst_a), .in_valid(iv_a), .in_data(id_a), .in_ready(ir_a),
    .flush(flush_a), .out_valid(ov_a), .out_data(od_a), .out_ready(ordy_a),
    .occupancy(occ_a)
  );

  pipe_stage_reg #(.WIDTH(W), .NOP_VALUE(B_NOP), .SKID(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .in_valid(iv_b), .in_data(id_b), .in_ready(ir_b),
    .flush(flush_b), .out_valid(ov_b), .out_data(od_b), .out_ready(ordy_b),
    .occupancy(occ_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string name, input logic ov, input logic [W-1:0] od,
                         input logic ir, input logic [1:0] occ);
    check({name, " a.out_valid"}, 64'(ov_a), 64'(ov));
    check({name, " a.out_data"},  64'(od_a), 64'(od));
    check({name, " a.in_ready"},  64'(ir_a), 64'(ir));
    check({name, " a.occupancy"}, 64'(occ_a), 64'(occ));
  endtask

  task automatic check_b(input string name, input logic ov, input logic [W-1:0] od,
                         input logic ir, input logic [1:0] occ);
    check({name, " b.out_valid"}, 64'(ov_b), 64'(ov));
    check({name, " b.out_data"},  64'(od_b), 64'(od));
    check({name, " b.in_ready"},  64'(ir_b), 64'(ir));
    check({name, " b.occupancy"}, 64'(occ_b), 64'(occ));
  endtask

  typedef struct {
    string        name;
    logic         rst, flush, iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         ov;
    logic [W-1:0] od;
    logic         ir;
    logic [1:0]   occ;
  } vec_t;

  function automatic vec_t mk(input string name, input logic rst, input logic flush,
                              input logic iv, input logic [W-1:0] id, input logic ordy,
                              input logic ov, input logic [W-1:0] od, input logic ir,
                              input logic [1:0] occ);
    vec_t v;
    v.name = name; v.rst = rst; v.flush = flush; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ov = ov; v.od = od; v.ir = ir; v.occ = occ;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  vec_t         vecs[$];
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  initial begin
    rst_a = 1'b1; flush_a = 1'b0; iv_a = 1'b0; id_a = '0; ordy_a = 1'b0;
    rst_b = 1'b1; flush_b = 1'b0; iv_b = 1'b0; id_b = '0; ordy_b = 1'b0;

    //               name       rst flu iv  data    ordy  ov  out_data ir occ
    vecs.push_back(mk("reset",   1, 0, 0, 48'h0,   0,    0, A_NOP,    1, 0));
    vecs.push_back(mk("strm1",   0, 0, 1, 48'h1,   1,    1, 48'h1,    1, 1));
    vecs.push_back(mk("strm2",   0, 0, 1, 48'h2,   1,    1, 48'h2,    1, 1));
    vecs.push_back(mk("strm3",   0, 0, 1, 48'h3,   1,    1, 48'h3,    1, 1));
    vecs.push_back(mk("strm4",   0, 0, 1, 48'h4,   1,    1, 48'h4,    1, 1));
    vecs.push_back(mk("drain",   0, 0, 0, 48'h0,   1,    0, A_NOP,    1, 0));
    vecs.push_back(mk("stallA",  0, 0, 1, 48'hA,   0,    1, 48'hA,    1, 1));
    vecs.push_back(mk("stallB",  0, 0, 1, 48'hB,   0,    1, 48'hA,    0, 2));
    vecs.push_back(mk("stallH1", 0, 0, 1, 48'hE,   0,    1, 48'hA,    0, 2));
    vecs.push_back(mk("stallH2", 0, 0, 0, 48'h0,   0,    1, 48'hA,    0, 2));
    vecs.push_back(mk("popA",    0, 0, 0, 48'h0,   1,    1, 48'hB,    1, 1));
    vecs.push_back(mk("popB",    0, 0, 0, 48'h0,   1,    0, A_NOP,    1, 0));
    vecs.push_back(mk("fl_p1",   0, 0, 1, 48'h11,  0,    1, 48'h11,   1, 1));
    vecs.push_back(mk("fl_p2",   0, 0, 1, 48'h12,  0,    1, 48'h11,   0, 2));
    vecs.push_back(mk("flushF",  0, 1, 1, 48'hC,   1,    0, A_NOP,    1, 0));
    vecs.push_back(mk("fl_noC",  0, 0, 0, 48'h0,   1,    0, A_NOP,    1, 0));
    vecs.push_back(mk("fl_p3",   0, 0, 1, 48'h21,  0,    1, 48'h21,   1, 1));
    vecs.push_back(mk("flushB",  0, 1, 1, 48'h22,  1,    0, A_NOP,    1, 0));
    vecs.push_back(mk("fl_no22", 0, 0, 0, 48'h0,   1,    0, A_NOP,    1, 0));
    vecs.push_back(mk("rs_p1",   0, 0, 1, 48'h31,  0,    1, 48'h31,   1, 1));
    vecs.push_back(mk("rs_p2",   0, 0, 1, 48'h32,  0,    1, 48'h31,   0, 2));
    vecs.push_back(mk("rstMid",  1, 1, 1, 48'h33,  1,    0, A_NOP,    1, 0));
    vecs.push_back(mk("rs_idle", 0, 0, 0, 48'h0,   1,    0, A_NOP,    1, 0));
    vecs.push_back(mk("sk_p1",   0, 0, 1, 48'h41,  0,    1, 48'h41,   1, 1));
    vecs.push_back(mk("sk_p2",   0, 0, 1, 48'h42,  0,    1, 48'h41,   0, 2));
    vecs.push_back(mk("sk_mv",   0, 0, 1, 48'h43,  1,    1, 48'h42,   1, 1));
    vecs.push_back(mk("sk_both", 0, 0, 1, 48'h44,  1,    1, 48'h44,   1, 1));
    vecs.push_back(mk("sk_end",  0, 0, 0, 48'h0,   1,    0, A_NOP,    1, 0));

    tick();
    rst_b = 1'b0;
    foreach (vecs[i]) begin
      rst_a = vecs[i].rst; flush_a = vecs[i].flush; iv_a = vecs[i].iv;
      id_a = vecs[i].id; ordy_a = vecs[i].ordy;
      tick();
      check_a(vecs[i].name, vecs[i].ov, vecs[i].od, vecs[i].ir, vecs[i].occ);
    end
    rst_a = 1'b0; flush_a = 1'b0; iv_a = 1'b0; ordy_a = 1'b0;

    // Single-entry stage: 5 accepted, in_ready low one cycle, 6 two cycles later.
    check_b("b_reset", 1'b0, B_NOP, 1'b1, 2'd0);
    iv_b = 1'b1; ordy_b = 1'b1; id_b = 48'h5;
    tick();
    check_b("b_acc5", 1'b1, 48'h5, 1'b0, 2'd1);
    id_b = 48'h6;
    tick();
    check_b("b_gap", 1'b0, B_NOP, 1'b1, 2'd0);
    tick();
    check_b("b_out6", 1'b1, 48'h6, 1'b0, 2'd1);
    iv_b = 1'b0;
    tick();
    check_b("b_drain", 1'b0, B_NOP, 1'b1, 2'd0);

    // Randomized traffic on both instances against a FIFO-of-capacity model.
    for (int c = 0; c < 600; c++) begin
      int  cap_a, cap_b;
      logic pa, pb;
      cap_a = 2; cap_b = 1;
      rst_a = ($urandom_range(63) == 0);  flush_a = ($urandom_range(15) == 0);
      iv_a = ($urandom_range(9) < 7);      ordy_a = ($urandom_range(9) < 6);
      id_a = rand_word();
      rst_b = ($urandom_range(63) == 0);  flush_b = ($urandom_range(15) == 0);
      iv_b = ($urandom_range(9) < 7);      ordy_b = ($urandom_range(9) < 6);
      id_b = rand_word();

      pa = iv_a && (qa.size() < cap_a);
      if (rst_a || flush_a) qa.delete();
      else begin
        if (ordy_a && qa.size() > 0) void'(qa.pop_front());
        if (pa) qa.push_back(id_a);
      end
      pb = iv_b && (qb.size() < cap_b);
      if (rst_b || flush_b) qb.delete();
      else begin
        if (ordy_b && qb.size() > 0) void'(qb.pop_front());
        if (pb) qb.push_back(id_b);
      end

      tick();
      check_a("rand", qa.size() > 0, (qa.size() > 0) ? qa[0] : A_NOP,
              qa.size() < cap_a, 2'(qa.size()));
      check_b("rand", qb.size() > 0, (qb.size() > 0) ? qb[0] : B_NOP,
              qb.size() < cap_b, 2'(qb.size()));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 48, payload width in bits (instruction fields packed LSB-first).
REQ-002 SHALL have parameter NOP_VALUE, default all-zeros of WIDTH, value presented on out_data whenever out_valid is low.
REQ-003 SHALL have parameter SKID, default 1; 1 = two-entry elastic stage with skid buffer, 0 = single-entry stage.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  upstream stage presents a valid word.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port in_ready  output  1  stage accepts a word this cycle.
REQ-009 SHALL have port flush  input  1  discard all held words (branch/hazard squash).
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-011 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-012 SHALL have port out_ready  input  1  downstream consumes the word this cycle.
REQ-013 SHALL have port occupancy  output  2  number of held words, 0..2 (0..1 when SKID=0).

Function
REQ-014 SHALL treat a transfer in as in_valid & in_ready, a transfer out as out_valid & out_ready, both sampled at the rising edge.
REQ-015 SHALL register all outputs; in_ready, out_valid, out_data and occupancy SHALL depend on no input combinationally.
REQ-016 SHALL have latency of exactly one cycle: a word accepted into an empty stage appears on out_data the next cycle.
REQ-017 SHALL (SKID=1) use states EMPTY (0 held), BUSY (main register full), FULL (main + skid full).
REQ-018 SHALL transition EMPTY->BUSY on transfer in; BUSY->EMPTY on transfer out without transfer in; BUSY->BUSY on both; BUSY->FULL on transfer in without transfer out; FULL->BUSY on transfer out (skid word moves to main register); all other cases hold state.
REQ-019 SHALL drive in_ready = 1 in EMPTY and BUSY, 0 in FULL, giving full throughput (one word per cycle) under continuous out_ready.
REQ-020 SHALL preserve order: the skid word is always emitted after the main-register word.
REQ-021 SHALL (SKID=0) drive in_ready = ~out_valid; one word every two cycles under continuous flow.
REQ-022 SHALL drive out_data = NOP_VALUE whenever out_valid = 0.
REQ-023 SHALL on flush = 1 go to EMPTY next cycle, dropping held words and any simultaneous input word; flush overrides in_valid and out_ready.
REQ-024 SHALL keep held data unchanged while out_ready = 0 (stall), for any stall length.
REQ-025 SHALL set occupancy equal to the state count every cycle.

Reset
REQ-026 SHALL on rst = 1 at a rising edge set state EMPTY: out_valid 0, out_data NOP_VALUE, in_ready 1 (0 when SKID=0 is not applicable; 1), occupancy 0.
REQ-027 SHALL give rst priority over flush and all handshakes; words held mid-operation are lost.

Structure
REQ-028 SHALL place NOP_VALUE defaults and the state encoding (EMPTY/BUSY/FULL) in shared package pipe_pkg.
REQ-029 SHALL be a single module; no sub-module; the datapath is one main and one skid register of WIDTH bits.

Verification
REQ-030 SHALL verify streaming: in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later, in_ready stays 1.
REQ-031 SHALL verify stall: push 0xA then 0xB with out_ready=0 -> occupancy 2, in_ready 0; raise out_ready -> 0xA then 0xB out, occupancy 1 then 0.
REQ-032 SHALL verify flush: occupancy 2, flush=1 with in_valid=1 data 0xC -> next cycle out_valid 0, out_data NOP_VALUE, occupancy 0, 0xC never emitted.
REQ-033 SHALL verify reset mid-operation: occupancy 2, rst=1 for one cycle -> out_valid 0, occupancy 0, in_ready 1 next cycle.
REQ-034 SHALL verify SKID=0: continuous in_valid/out_ready with data 5,6 -> 5 accepted, in_ready 0 one cycle, 6 emitted two cycles after 5.
